// File: rtl/c1541_gcr_decoder.sv
// Serial GCR decoder for the 1541 write path: finds SYNC marks, frames 10-bit
// groups into bytes, checks header/data blocks and streams payload bytes to RAM.
module c1541_gcr_decoder (
    input  logic       clk32,
    input  logic       reset,
    input  logic       bit_en,
    input  logic       bit_in,
    input  logic [5:0] track,
    output logic       sync_n,
    output logic [4:0] sector,
    output logic [7:0] byte_addr,
    output logic [7:0] ram_di,
    output logic       ram_we,
    output logic       blk_done,
    output logic       blk_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ID   = 2'd1;
    localparam logic [1:0] ST_HDR  = 2'd2;
    localparam logic [1:0] ST_DATA = 2'd3;

    logic [1:0] state_q, state_d;
    logic [3:0] ones_cnt_q, ones_cnt_d;
    logic       sync_n_q, sync_n_d;
    logic [4:0] sector_q, sector_d;
    logic [7:0] byte_addr_q, byte_addr_d;
    logic [7:0] ram_di_q, ram_di_d;
    logic       ram_we_q, ram_we_d;
    logic       blk_done_q, blk_done_d;
    logic       blk_err_q, blk_err_d;
    logic       hdr_valid_q, hdr_valid_d;
    logic [5:0] track_q, track_d;
    logic [8:0] shift_q, shift_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [8:0] byte_cnt_q, byte_cnt_d;
    logic [7:0] cks_q, cks_d;
    logic [7:0] hdr_cks_q, hdr_cks_d;
    logic [7:0] hdr_sec_q, hdr_sec_d;
    logic [7:0] hdr_trk_q, hdr_trk_d;
    logic       bad_q, bad_d;

    logic [9:0] group;
    logic [4:0] hi_dec, lo_dec;
    logic [7:0] byte_val;
    logic       byte_bad, bad_now, hdr_ok;
    logic [3:0] ones_next;

    // Returns {valid, nibble}; unlisted quintets come back with valid = 0.
    function automatic logic [4:0] gcr_dec(input logic [4:0] q);
        logic [4:0] r;
        case (q)
            5'b01010: r = 5'h10;
            5'b01011: r = 5'h11;
            5'b10010: r = 5'h12;
            5'b10011: r = 5'h13;
            5'b01110: r = 5'h14;
            5'b01111: r = 5'h15;
            5'b10110: r = 5'h16;
            5'b10111: r = 5'h17;
            5'b01001: r = 5'h18;
            5'b11001: r = 5'h19;
            5'b11010: r = 5'h1A;
            5'b11011: r = 5'h1B;
            5'b01101: r = 5'h1C;
            5'b11101: r = 5'h1D;
            5'b11110: r = 5'h1E;
            5'b10101: r = 5'h1F;
            default:  r = 5'h00;
        endcase
        return r;
    endfunction

    always_comb begin
        group     = {shift_q, bit_in};
        hi_dec    = gcr_dec(group[9:5]);
        lo_dec    = gcr_dec(group[4:0]);
        byte_val  = {hi_dec[3:0], lo_dec[3:0]};
        byte_bad  = !hi_dec[4] || !lo_dec[4];
        bad_now   = bad_q || byte_bad;
        ones_next = bit_in ? ((ones_cnt_q == 4'd15) ? 4'd15 : ones_cnt_q + 4'd1) : 4'd0;
        // At header byte 5 cks_q already holds sec^trk^id2; byte_val is id1.
        hdr_ok    = !bad_now && (hdr_cks_q == (cks_q ^ byte_val)) &&
                    (hdr_trk_q == {2'b00, track}) && (hdr_sec_q <= 8'd20);

        state_d     = state_q;
        ones_cnt_d  = ones_cnt_q;
        sync_n_d    = sync_n_q;
        sector_d    = sector_q;
        byte_addr_d = byte_addr_q;
        ram_di_d    = ram_di_q;
        ram_we_d    = 1'b0;
        blk_done_d  = 1'b0;
        blk_err_d   = 1'b0;
        hdr_valid_d = hdr_valid_q;
        track_d     = track_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        cks_d       = cks_q;
        hdr_cks_d   = hdr_cks_q;
        hdr_sec_d   = hdr_sec_q;
        hdr_trk_d   = hdr_trk_q;
        bad_d       = bad_q;

        if (track != track_q) begin
            track_d     = track;
            hdr_valid_d = 1'b0;
            sector_d    = 5'd0;
            state_d     = ST_IDLE;
        end else if (bit_en) begin
            ones_cnt_d = ones_next;
            sync_n_d   = !(ones_next >= 4'd10);
            if (bit_in && (ones_cnt_q == 4'd9)) begin
                state_d = ST_IDLE;
                if (state_q == ST_DATA) blk_err_d = 1'b1;
            end else if (!bit_in && (ones_cnt_q >= 4'd10)) begin
                // The terminating 0 is the first bit of the ID byte group.
                state_d    = ST_ID;
                shift_d    = 9'd0;
                bit_cnt_d  = 4'd1;
                byte_cnt_d = 9'd0;
                cks_d      = 8'd0;
                bad_d      = 1'b0;
            end else if (state_q != ST_IDLE) begin
                shift_d = group[8:0];
                if (bit_cnt_q == 4'd9) begin
                    bit_cnt_d  = 4'd0;
                    byte_cnt_d = byte_cnt_q + 9'd1;
                    bad_d      = bad_now;
                    case (state_q)
                        ST_ID: begin
                            if (!byte_bad && byte_val == 8'h08)
                                state_d = ST_HDR;
                            else if (!byte_bad && byte_val == 8'h07 && hdr_valid_q)
                                state_d = ST_DATA;
                            else
                                state_d = ST_IDLE;
                        end
                        ST_HDR: begin
                            case (byte_cnt_q)
                                9'd1: hdr_cks_d = byte_val;
                                9'd2: begin hdr_sec_d = byte_val; cks_d = cks_q ^ byte_val; end
                                9'd3: begin hdr_trk_d = byte_val; cks_d = cks_q ^ byte_val; end
                                9'd4: cks_d = cks_q ^ byte_val;
                                default: begin
                                    if (hdr_ok) begin
                                        sector_d    = hdr_sec_q[4:0];
                                        hdr_valid_d = 1'b1;
                                    end else begin
                                        hdr_valid_d = 1'b0;
                                        blk_err_d   = 1'b1;
                                    end
                                    state_d = ST_IDLE;
                                end
                            endcase
                        end
                        ST_DATA: begin
                            if (byte_cnt_q <= 9'd256) begin
                                byte_addr_d = byte_cnt_q[7:0] - 8'd1;
                                ram_di_d    = byte_val;
                                ram_we_d    = 1'b1;
                                cks_d       = cks_q ^ byte_val;
                            end else begin
                                if (!bad_now && byte_val == cks_q) blk_done_d = 1'b1;
                                else                               blk_err_d  = 1'b1;
                                hdr_valid_d = 1'b0;
                                state_d     = ST_IDLE;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ones_cnt_q  <= 4'd0;
            sync_n_q    <= 1'b1;
            sector_q    <= 5'd0;
            byte_addr_q <= 8'd0;
            ram_di_q    <= 8'd0;
            ram_we_q    <= 1'b0;
            blk_done_q  <= 1'b0;
            blk_err_q   <= 1'b0;
            hdr_valid_q <= 1'b0;
            track_q     <= 6'd0;
            shift_q     <= 9'd0;
            bit_cnt_q   <= 4'd0;
            byte_cnt_q  <= 9'd0;
            cks_q       <= 8'd0;
            hdr_cks_q   <= 8'd0;
            hdr_sec_q   <= 8'd0;
            hdr_trk_q   <= 8'd0;
            bad_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ones_cnt_q  <= ones_cnt_d;
            sync_n_q    <= sync_n_d;
            sector_q    <= sector_d;
            byte_addr_q <= byte_addr_d;
            ram_di_q    <= ram_di_d;
            ram_we_q    <= ram_we_d;
            blk_done_q  <= blk_done_d;
            blk_err_q   <= blk_err_d;
            hdr_valid_q <= hdr_valid_d;
            track_q     <= track_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            cks_q       <= cks_d;
            hdr_cks_q   <= hdr_cks_d;
            hdr_sec_q   <= hdr_sec_d;
            hdr_trk_q   <= hdr_trk_d;
            bad_q       <= bad_d;
        end
    end

    assign sync_n    = sync_n_q;
    assign sector    = sector_q;
    assign byte_addr = byte_addr_q;
    assign ram_di    = ram_di_q;
    assign ram_we    = ram_we_q;
    assign blk_done  = blk_done_q;
    assign blk_err   = blk_err_q;

endmodule

// File: tb/tb_c1541_gcr_decoder.sv
// Bench for c1541_gcr_decoder: encodes byte-level blocks to GCR and predicts
// writes and block pulses from header/data block rules.
module tb_c1541_gcr_decoder;

    logic       clk32 = 1'b0;
    logic       reset;
    logic       bit_en;
    logic       bit_in;
    logic [5:0] track;
    logic       sync_n;
    logic [4:0] sector;
    logic [7:0] byte_addr;
    logic [7:0] ram_di;
    logic       ram_we;
    logic       blk_done;
    logic       blk_err;

    c1541_gcr_decoder dut (
        .clk32     (clk32),
        .reset     (reset),
        .bit_en    (bit_en),
        .bit_in    (bit_in),
        .track     (track),
        .sync_n    (sync_n),
        .sector    (sector),
        .byte_addr (byte_addr),
        .ram_di    (ram_di),
        .ram_we    (ram_we),
        .blk_done  (blk_done),
        .blk_err   (blk_err)
    );

    always #5 clk32 = ~clk32;

    logic [4:0] gcr_tab [16] = '{5'b01010, 5'b01011, 5'b10010, 5'b10011,
                                 5'b01110, 5'b01111, 5'b10110, 5'b10111,
                                 5'b01001, 5'b11001, 5'b11010, 5'b11011,
                                 5'b01101, 5'b11101, 5'b11110, 5'b10101};

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] wr_q [$];
    int          done_cnt = 0;
    int          err_cnt  = 0;
    bit          both_seen = 1'b0;
    bit          we_wide   = 1'b0;
    logic        prev_we   = 1'b0;
    logic [7:0]  pay [256];
    logic [4:0]  m_sector;
    bit          m_hdr_valid;

    always @(negedge clk32) begin
        if (ram_we === 1'b1) wr_q.push_back({byte_addr, ram_di});
        if (blk_done === 1'b1) done_cnt++;
        if (blk_err === 1'b1) err_cnt++;
        if (blk_done === 1'b1 && blk_err === 1'b1) both_seen = 1'b1;
        if (ram_we === 1'b1 && prev_we === 1'b1) we_wide = 1'b1;
        prev_we = ram_we;
    end

    task automatic clear_mon();
        wr_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk32);
        bit_en = 1'b1;
        bit_in = b;
        @(negedge clk32);
        bit_en = 1'b0;
    endtask

    task automatic send_raw(input logic [9:0] g);
        for (int i = 9; i >= 0; i--) send_bit(g[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_raw({gcr_tab[b[7:4]], gcr_tab[b[3:0]]});
    endtask

    task automatic send_sync(input int n);
        repeat (n) send_bit(1'b1);
    endtask

    task automatic send_header(input logic [7:0] sec, input logic [7:0] trk,
                               input logic [7:0] id2, input logic [7:0] id1,
                               input logic corrupt);
        logic [7:0] ck;
        ck = sec ^ trk ^ id2 ^ id1 ^ {7'd0, corrupt};
        send_sync(12);
        send_byte(8'h08);
        send_byte(ck);
        send_byte(sec);
        send_byte(trk);
        send_byte(id2);
        send_byte(id1);
        send_byte(8'h0F);
    endtask

    task automatic send_data_block(input logic [7:0] ck);
        send_sync(12);
        send_byte(8'h07);
        for (int i = 0; i < 256; i++) send_byte(pay[i]);
        send_byte(ck);
        send_byte(8'h0F);
    endtask

    function automatic logic [7:0] pay_xor();
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 256; i++) x ^= pay[i];
        return x;
    endfunction

    function automatic int write_errs(input int skip);
        int e = 0;
        for (int i = 0; i < wr_q.size() && i < 256; i++)
            if (i != skip && wr_q[i] !== {i[7:0], pay[i]}) e++;
        return e;
    endfunction

    task automatic test_reset();
        reset = 1'b1; bit_en = 1'b0; bit_in = 1'b0; track = 6'd18;
        repeat (3) @(negedge clk32);
        n_checks++; if (sync_n !== 1'b1)    begin n_fail++; $display("FAIL rst_sync_n: got %b expected 1", sync_n); end
        n_checks++; if (sector !== 5'd0)    begin n_fail++; $display("FAIL rst_sector: got %0d expected 0", sector); end
        n_checks++; if (byte_addr !== 8'd0) begin n_fail++; $display("FAIL rst_byte_addr: got %0d expected 0", byte_addr); end
        n_checks++; if (ram_di !== 8'd0)    begin n_fail++; $display("FAIL rst_ram_di: got %0d expected 0", ram_di); end
        n_checks++; if (ram_we !== 1'b0)    begin n_fail++; $display("FAIL rst_ram_we: got %b expected 0", ram_we); end
        n_checks++; if (blk_done !== 1'b0)  begin n_fail++; $display("FAIL rst_blk_done: got %b expected 0", blk_done); end
        n_checks++; if (blk_err !== 1'b0)   begin n_fail++; $display("FAIL rst_blk_err: got %b expected 0", blk_err); end
        reset = 1'b0;
        repeat (4) @(negedge clk32);
        m_sector = 5'd0;
        m_hdr_valid = 1'b0;
    endtask

    task automatic test_sync_header();
        logic [9:0] g;
        clear_mon();
        send_sync(9);
        n_checks++; if (sync_n !== 1'b1) begin n_fail++; $display("FAIL sync_9_ones: got %b expected 1", sync_n); end
        send_bit(1'b1);
        n_checks++; if (sync_n !== 1'b0) begin n_fail++; $display("FAIL sync_10_ones: got %b expected 0", sync_n); end
        send_sync(2);
        n_checks++; if (sync_n !== 1'b0) begin n_fail++; $display("FAIL sync_12_ones: got %b expected 0", sync_n); end
        g = {gcr_tab[0], gcr_tab[8]};
        send_bit(g[9]);
        n_checks++; if (sync_n !== 1'b1) begin n_fail++; $display("FAIL sync_end: got %b expected 1", sync_n); end
        for (int i = 8; i >= 0; i--) send_bit(g[i]);
        send_byte(8'h12); send_byte(8'h03); send_byte(8'h12); send_byte(8'h42); send_byte(8'h41);
        send_byte(8'h0F);
        m_sector = 5'd3; m_hdr_valid = 1'b1;
        n_checks++; if (sector !== m_sector) begin n_fail++; $display("FAIL hdr_sector: got %0d expected %0d", sector, m_sector); end
        n_checks++; if (err_cnt !== 0) begin n_fail++; $display("FAIL hdr_no_err: got %0d expected 0", err_cnt); end
    endtask

    task automatic test_data_ok();
        for (int i = 0; i < 256; i++) pay[i] = i[7:0];
        send_header(8'd3, 8'd18, 8'h42, 8'h41, 1'b0);
        clear_mon();
        send_sync(12);
        send_byte(8'h07);
        send_byte(pay[0]);
        n_checks++; if (ram_we !== 1'b1 || byte_addr !== 8'd0 || ram_di !== 8'd0)
            begin n_fail++; $display("FAIL first_write: got we=%b addr=%0d di=%0d expected we=1 addr=0 di=0", ram_we, byte_addr, ram_di); end
        for (int i = 1; i < 256; i++) send_byte(pay[i]);
        send_byte(pay_xor());
        n_checks++; if (blk_done !== 1'b1) begin n_fail++; $display("FAIL done_timing: got %b expected 1", blk_done); end
        send_byte(8'h0F);
        m_hdr_valid = 1'b0;
        n_checks++; if (wr_q.size() !== 256) begin n_fail++; $display("FAIL ok_write_count: got %0d expected 256", wr_q.size()); end
        n_checks++; if (write_errs(-1) !== 0) begin n_fail++; $display("FAIL ok_write_data: got %0d bad writes expected 0", write_errs(-1)); end
        n_checks++; if (done_cnt !== 1 || err_cnt !== 0)
            begin n_fail++; $display("FAIL ok_pulses: got done=%0d err=%0d expected done=1 err=0", done_cnt, err_cnt); end
    endtask

    task automatic test_bad_cks();
        for (int i = 0; i < 256; i++) pay[i] = i[7:0];
        send_header(8'd3, 8'd18, 8'h42, 8'h41, 1'b0);
        clear_mon();
        send_data_block(8'h01);
        n_checks++; if (wr_q.size() !== 256) begin n_fail++; $display("FAIL badck_write_count: got %0d expected 256", wr_q.size()); end
        n_checks++; if (done_cnt !== 0 || err_cnt !== 1)
            begin n_fail++; $display("FAIL badck_pulses: got done=%0d err=%0d expected done=0 err=1", done_cnt, err_cnt); end
        clear_mon();
        send_data_block(8'h00);
        n_checks++; if (wr_q.size() !== 0 || done_cnt !== 0 || err_cnt !== 0)
            begin n_fail++; $display("FAIL noheader_block: got writes=%0d done=%0d err=%0d expected 0/0/0", wr_q.size(), done_cnt, err_cnt); end
        m_hdr_valid = 1'b0;
    endtask

    task automatic test_wrong_track();
        clear_mon();
        send_header(8'd5, 8'h13, 8'h42, 8'h41, 1'b0);
        n_checks++; if (err_cnt !== 1) begin n_fail++; $display("FAIL wtrk_err: got %0d expected 1", err_cnt); end
        n_checks++; if (sector !== m_sector) begin n_fail++; $display("FAIL wtrk_sector: got %0d expected %0d", sector, m_sector); end
        clear_mon();
        send_data_block(pay_xor());
        n_checks++; if (wr_q.size() !== 0 || done_cnt !== 0 || err_cnt !== 0)
            begin n_fail++; $display("FAIL wtrk_block: got writes=%0d done=%0d err=%0d expected 0/0/0", wr_q.size(), done_cnt, err_cnt); end
    endtask

    task automatic test_bad_quintet();
        for (int i = 0; i < 256; i++) pay[i] = 8'($urandom_range(0, 255));
        send_header(8'd7, 8'd18, 8'h11, 8'h22, 1'b0);
        m_sector = 5'd7;
        n_checks++; if (sector !== m_sector) begin n_fail++; $display("FAIL bq_sector: got %0d expected %0d", sector, m_sector); end
        clear_mon();
        send_sync(12);
        send_byte(8'h07);
        for (int i = 0; i < 256; i++) begin
            if (i == 9) send_raw({5'b00000, gcr_tab[pay[i][3:0]]});
            else        send_byte(pay[i]);
        end
        send_byte(pay_xor());
        send_byte(8'h0F);
        n_checks++; if (wr_q.size() !== 256) begin n_fail++; $display("FAIL bq_write_count: got %0d expected 256", wr_q.size()); end
        n_checks++; if (write_errs(9) !== 0) begin n_fail++; $display("FAIL bq_write_data: got %0d bad writes expected 0", write_errs(9)); end
        n_checks++; if (done_cnt !== 0 || err_cnt !== 1)
            begin n_fail++; $display("FAIL bq_pulses: got done=%0d err=%0d expected done=0 err=1", done_cnt, err_cnt); end
        m_hdr_valid = 1'b0;
    endtask

    task automatic test_sync_abort();
        for (int i = 0; i < 256; i++) pay[i] = i[7:0];
        send_header(8'd9, 8'd18, 8'h42, 8'h41, 1'b0);
        m_sector = 5'd9;
        clear_mon();
        send_sync(12);
        send_byte(8'h07);
        for (int i = 0; i < 99; i++) send_byte(pay[i]);
        send_sync(9);
        send_bit(1'b1);
        n_checks++; if (blk_err !== 1'b1) begin n_fail++; $display("FAIL abort_err_timing: got %b expected 1", blk_err); end
        n_checks++; if (sync_n !== 1'b0) begin n_fail++; $display("FAIL abort_sync_n: got %b expected 0", sync_n); end
        repeat (3) @(negedge clk32);
        n_checks++; if (wr_q.size() !== 99 || err_cnt !== 1 || done_cnt !== 0)
            begin n_fail++; $display("FAIL abort_counts: got writes=%0d err=%0d done=%0d expected 99/1/0", wr_q.size(), err_cnt, done_cnt); end
    endtask

    task automatic test_track_change();
        for (int i = 0; i < 256; i++) pay[i] = i[7:0];
        send_header(8'd11, 8'd18, 8'h42, 8'h41, 1'b0);
        m_sector = 5'd11;
        n_checks++; if (sector !== m_sector) begin n_fail++; $display("FAIL tc_sector_before: got %0d expected %0d", sector, m_sector); end
        clear_mon();
        send_sync(12);
        send_byte(8'h07);
        for (int i = 0; i < 50; i++) send_byte(pay[i]);
        @(negedge clk32);
        track = 6'd20;
        repeat (2) @(negedge clk32);
        m_sector = 5'd0; m_hdr_valid = 1'b0;
        n_checks++; if (sector !== m_sector) begin n_fail++; $display("FAIL tc_sector_after: got %0d expected 0", sector); end
        for (int i = 50; i < 256; i++) send_byte(pay[i]);
        send_byte(pay_xor());
        send_byte(8'h0F);
        n_checks++; if (wr_q.size() !== 50 || err_cnt !== 0 || done_cnt !== 0)
            begin n_fail++; $display("FAIL tc_counts: got writes=%0d err=%0d done=%0d expected 50/0/0", wr_q.size(), err_cnt, done_cnt); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 256; i++) pay[i] = 8'($urandom_range(0, 255));
        send_header(8'd4, {2'b00, track}, 8'h42, 8'h41, 1'b0);
        send_sync(12);
        send_byte(8'h07);
        for (int i = 0; i < 30; i++) send_byte(pay[i]);
        @(negedge clk32);
        reset = 1'b1;
        #1;
        n_checks++; if (sync_n !== 1'b1 || sector !== 5'd0 || byte_addr !== 8'd0 || ram_di !== 8'd0 ||
                        ram_we !== 1'b0 || blk_done !== 1'b0 || blk_err !== 1'b0)
            begin n_fail++; $display("FAIL midreset_outputs: got sync_n=%b sector=%0d addr=%0d di=%0d we=%b done=%b err=%b expected reset values",
                                     sync_n, sector, byte_addr, ram_di, ram_we, blk_done, blk_err); end
        repeat (2) @(negedge clk32);
        reset = 1'b0;
        repeat (3) @(negedge clk32);
        m_sector = 5'd0; m_hdr_valid = 1'b0;
        clear_mon();
        send_sync(12);
        send_byte(8'h07);
        for (int i = 0; i < 3; i++) send_byte(pay[i]);
        n_checks++; if (wr_q.size() !== 0) begin n_fail++; $display("FAIL midreset_hdr_cleared: got %0d writes expected 0", wr_q.size()); end
    endtask

    task automatic test_random();
        logic [7:0] sec, trk, id2, id1, ck;
        bit corrupt, wrong_trk, bad_ck, hv;
        for (int it = 0; it < 4; it++) begin
            sec       = 8'($urandom_range(0, 31));
            wrong_trk = ($urandom_range(0, 3) == 0);
            corrupt   = ($urandom_range(0, 3) == 0);
            trk       = {2'b00, track} ^ {7'd0, wrong_trk};
            id2       = 8'($urandom_range(0, 255));
            id1       = 8'($urandom_range(0, 255));
            hv        = !corrupt && !wrong_trk && (sec <= 8'd20);
            clear_mon();
            send_header(sec, trk, id2, id1, corrupt);
            if (hv) m_sector = sec[4:0];
            m_hdr_valid = hv;
            n_checks++; if (err_cnt !== (hv ? 0 : 1)) begin n_fail++; $display("FAIL rnd_hdr_err[%0d]: got %0d expected %0d", it, err_cnt, hv ? 0 : 1); end
            n_checks++; if (sector !== m_sector) begin n_fail++; $display("FAIL rnd_sector[%0d]: got %0d expected %0d", it, sector, m_sector); end
            for (int i = 0; i < 256; i++) pay[i] = 8'($urandom_range(0, 255));
            bad_ck = ($urandom_range(0, 2) == 0);
            ck = pay_xor() ^ (bad_ck ? 8'h5A : 8'h00);
            clear_mon();
            send_data_block(ck);
            n_checks++; if (wr_q.size() !== (m_hdr_valid ? 256 : 0))
                begin n_fail++; $display("FAIL rnd_write_count[%0d]: got %0d expected %0d", it, wr_q.size(), m_hdr_valid ? 256 : 0); end
            n_checks++; if (write_errs(-1) !== 0) begin n_fail++; $display("FAIL rnd_write_data[%0d]: got %0d bad writes expected 0", it, write_errs(-1)); end
            n_checks++; if (done_cnt !== ((m_hdr_valid && !bad_ck) ? 1 : 0) || err_cnt !== ((m_hdr_valid && bad_ck) ? 1 : 0))
                begin n_fail++; $display("FAIL rnd_pulses[%0d]: got done=%0d err=%0d expected done=%0d err=%0d", it, done_cnt, err_cnt,
                                         (m_hdr_valid && !bad_ck) ? 1 : 0, (m_hdr_valid && bad_ck) ? 1 : 0); end
            m_hdr_valid = 1'b0;
        end
    endtask

    task automatic test_pulse_shape();
        n_checks++; if (both_seen !== 1'b0) begin n_fail++; $display("FAIL done_err_exclusive: got overlap=%b expected 0", both_seen); end
        n_checks++; if (we_wide !== 1'b0) begin n_fail++; $display("FAIL ram_we_width: got wide=%b expected 0", we_wide); end
    endtask

    initial begin
        test_reset();
        test_sync_header();
        test_data_ok();
        test_bad_cks();
        test_wrong_track();
        test_bad_quintet();
        test_sync_abort();
        test_track_change();
        test_reset_mid();
        test_random();
        test_pulse_shape();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
